// File: rtl/cpu_pkg.sv
// Shared CPU control definitions.
// Holds the instruction-class codes seen by the PC sequencer, the PC source
// mux encodings, the exception cause codes and the default address of the
// first exception vector byte. exc_priority() resolves simultaneous
// exception flags to a single cause.
package cpu_pkg;

  typedef enum logic [2:0] {
    IC_SEQ = 3'd0,
    IC_BEQ = 3'd1,
    IC_BNE = 3'd2,
    IC_J   = 3'd3,
    IC_JR  = 3'd4,
    IC_RTE = 3'd5
  } instr_class_t;  // codes 6 and 7 are reserved

  typedef enum logic [2:0] {
    PCSRC_LS_CONTROL = 3'd0,  // LSControlOut (vector byte from memory)
    PCSRC_ALU_RESULT = 3'd1,  // aluResult
    PCSRC_ALU_OUT    = 3'd2,  // aluOutOut (branch target)
    PCSRC_SHIFT_L2   = 3'd3,  // shiftLeft2Out (jump target)
    PCSRC_EPC        = 3'd4   // epcOut
  } pcsrc_t;

  typedef enum logic [1:0] {
    EXC_NONE       = 2'd0,
    EXC_OP_INVALID = 2'd1,
    EXC_OVERFLOW   = 2'd2,
    EXC_DIV_ZERO   = 2'd3
  } exc_cause_t;

  localparam logic [7:0] VEC_BASE_DEFAULT = 8'd253;

  // opInvalid outranks overflow, which outranks divZero.
  function automatic exc_cause_t exc_priority(input logic op_invalid,
                                              input logic overflow,
                                              input logic div_zero);
    if (op_invalid)    return EXC_OP_INVALID;
    else if (overflow) return EXC_OVERFLOW;
    else if (div_zero) return EXC_DIV_ZERO;
    else               return EXC_NONE;
  endfunction

endpackage

// File: rtl/pc_sequencer.sv
// Multicycle PC update sequencer.
// Once per instruction it picks the PC source mux select and strobes the PC
// write. Exceptions run EPC save -> vector byte read -> memory wait -> PC
// load from the load/store control output.
//
// Ports:
//   clk          clock, rising edge
//   reset        asynchronous, active-high
//   start        one-cycle pulse: instruction decoded, operands/flags valid
//   instrClass   instruction class (SEQ/BEQ/BNE/J/JR/RTE, 6-7 reserved)
//   zero         ALU zero flag, sampled at start
//   opInvalid    invalid-opcode exception, sampled at start
//   overflow     overflow exception, sampled at start
//   divZero      divide-by-zero exception, sampled at start
//   muxpcsource  PC source select; holds its last value when not driven
//   pcWrite      PC load strobe
//   epcWrite     EPC load strobe (datapath presents PC-4 on aluResult)
//   memRead      vector fetch read strobe
//   vecAddr      vector byte address, VEC_BASE + cause index
//   excCause     latched exception cause, held until the next start
//   busy         high whenever the sequencer is not idle
//   done         pulse in the PC write cycle or in a not-taken branch decision
//
// MEM_WAIT must lie in 1..7 (memory read latency in cycles).
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int         MEM_WAIT = 2,
  parameter logic [7:0] VEC_BASE = VEC_BASE_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] instrClass,
  input  logic       zero,
  input  logic       opInvalid,
  input  logic       overflow,
  input  logic       divZero,
  output logic [2:0] muxpcsource,
  output logic       pcWrite,
  output logic       epcWrite,
  output logic       memRead,
  output logic [7:0] vecAddr,
  output logic [1:0] excCause,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_EXC_EPC,
    S_EXC_READ,
    S_EXC_WAIT,
    S_EXC_LOAD
  } state_t;

  state_t     state_reg, state_next;
  logic [2:0] class_reg, class_next;
  logic       zero_reg, zero_next;
  exc_cause_t cause_reg, cause_next;
  logic [7:0] vec_reg, vec_next;
  logic [2:0] wait_cnt_reg, wait_cnt_next;
  pcsrc_t     mux_reg, mux_next;
  exc_cause_t start_cause;

  assign start_cause = exc_priority(opInvalid, overflow, divZero);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      class_reg    <= 3'd0;
      zero_reg     <= 1'b0;
      cause_reg    <= EXC_NONE;
      vec_reg      <= 8'd0;
      wait_cnt_reg <= 3'd0;
      mux_reg      <= PCSRC_LS_CONTROL;
    end else begin
      state_reg    <= state_next;
      class_reg    <= class_next;
      zero_reg     <= zero_next;
      cause_reg    <= cause_next;
      vec_reg      <= vec_next;
      wait_cnt_reg <= wait_cnt_next;
      mux_reg      <= mux_next;
    end
  end

  // Next-state and output decode. Every output depends only on registered
  // state, so no input reaches an output combinationally.
  always_comb begin
    state_next    = state_reg;
    class_next    = class_reg;
    zero_next     = zero_reg;
    cause_next    = cause_reg;
    vec_next      = vec_reg;
    wait_cnt_next = wait_cnt_reg;
    mux_next      = mux_reg;
    pcWrite       = 1'b0;
    epcWrite      = 1'b0;
    memRead       = 1'b0;
    done          = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          class_next = instrClass;
          zero_next  = zero;
          cause_next = start_cause;
          if (start_cause != EXC_NONE) begin
            // Vector table starts at cause 1, hence the -1.
            vec_next   = VEC_BASE + 8'(start_cause) - 8'd1;
            state_next = S_EXC_EPC;
          end else begin
            state_next = S_APPLY;
          end
        end
      end

      S_APPLY: begin
        done = 1'b1;
        case (class_reg)
          IC_SEQ: begin mux_next = PCSRC_ALU_RESULT; pcWrite = 1'b1;      end
          IC_BEQ: begin mux_next = PCSRC_ALU_OUT;    pcWrite = zero_reg;  end
          IC_BNE: begin mux_next = PCSRC_ALU_OUT;    pcWrite = !zero_reg; end
          IC_J:   begin mux_next = PCSRC_SHIFT_L2;   pcWrite = 1'b1;      end
          IC_JR:  begin mux_next = PCSRC_ALU_RESULT; pcWrite = 1'b1;      end
          IC_RTE: begin mux_next = PCSRC_EPC;        pcWrite = 1'b1;      end
          default: ;  // reserved class: no-op, decoder raises opInvalid
        endcase
        state_next = S_IDLE;
      end

      S_EXC_EPC: begin
        epcWrite   = 1'b1;
        state_next = S_EXC_READ;
      end

      S_EXC_READ: begin
        memRead = 1'b1;
        if (MEM_WAIT > 1) begin
          wait_cnt_next = 3'(MEM_WAIT - 1);
          state_next    = S_EXC_WAIT;
        end else begin
          state_next = S_EXC_LOAD;
        end
      end

      S_EXC_WAIT: begin
        if (wait_cnt_reg <= 3'd1) begin
          wait_cnt_next = 3'd0;
          state_next    = S_EXC_LOAD;
        end else begin
          wait_cnt_next = wait_cnt_reg - 3'd1;
        end
      end

      S_EXC_LOAD: begin
        mux_next   = PCSRC_LS_CONTROL;
        pcWrite    = 1'b1;
        done       = 1'b1;
        state_next = S_IDLE;
      end

      default: state_next = S_IDLE;
    endcase
  end

  // In the cycles that set a new select, present it immediately; otherwise
  // the held value shows.
  assign muxpcsource = mux_next;
  assign vecAddr     = vec_reg;
  assign excCause    = cause_reg;
  assign busy        = (state_reg != S_IDLE);

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: one instance with MEM_WAIT=2, one with
// MEM_WAIT=1. Stimulus pushes expected strobe events (with the cycle they
// must appear in) into a per-instance queue; a monitor pops and compares
// whenever an instance raises pcWrite, epcWrite, memRead or done.
module tb_pc_sequencer;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       start_s [2];
  logic [2:0] cls_s   [2];
  logic       zero_s  [2];
  logic       oi_s    [2];
  logic       ov_s    [2];
  logic       dz_s    [2];
  logic [2:0] mux_o   [2];
  logic       pcw_o   [2];
  logic       epcw_o  [2];
  logic       mr_o    [2];
  logic [7:0] vec_o   [2];
  logic [1:0] cause_o [2];
  logic       busy_o  [2];
  logic       done_o  [2];

  pc_sequencer #(.MEM_WAIT(2), .VEC_BASE(8'd253)) dut_a (
    .clk(clk), .reset(reset), .start(start_s[0]), .instrClass(cls_s[0]),
    .zero(zero_s[0]), .opInvalid(oi_s[0]), .overflow(ov_s[0]), .divZero(dz_s[0]),
    .muxpcsource(mux_o[0]), .pcWrite(pcw_o[0]), .epcWrite(epcw_o[0]),
    .memRead(mr_o[0]), .vecAddr(vec_o[0]), .excCause(cause_o[0]),
    .busy(busy_o[0]), .done(done_o[0])
  );

  pc_sequencer #(.MEM_WAIT(1), .VEC_BASE(8'd253)) dut_b (
    .clk(clk), .reset(reset), .start(start_s[1]), .instrClass(cls_s[1]),
    .zero(zero_s[1]), .opInvalid(oi_s[1]), .overflow(ov_s[1]), .divZero(dz_s[1]),
    .muxpcsource(mux_o[1]), .pcWrite(pcw_o[1]), .epcWrite(epcw_o[1]),
    .memRead(mr_o[1]), .vecAddr(vec_o[1]), .excCause(cause_o[1]),
    .busy(busy_o[1]), .done(done_o[1])
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int         cyc;
    logic       pc;
    logic       epc;
    logic       mem;
    logic       dn;
    logic       chk_mux;
    logic [2:0] mux;
    logic [7:0] vaddr;
    logic [1:0] cause;
  } ev_t;

  ev_t q0[$];
  ev_t q1[$];

  task automatic push(input int i, input ev_t e);
    if (i == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Issue one start pulse on instance i. Called just after a rising edge;
  // the start is sampled at the next edge (edge N). Expected values are
  // hand-supplied by the caller.
  task automatic issue(input int i, input logic [2:0] cls, input logic z,
                       input logic oi, input logic ov, input logic dz,
                       input logic [2:0] exp_mux, input logic exp_pcw,
                       input logic [1:0] exp_cause, input logic [7:0] exp_vaddr);
    int   base;
    int   mw;
    logic chk_m;
    base  = cyc + 1;  // cycle counter value during cycle N+1
    mw    = (i == 0) ? 2 : 1;
    chk_m = (cls < 3'd6);
    if (exp_cause != 2'd0) begin
      push(i, '{base,          1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, exp_vaddr, exp_cause});
      push(i, '{base + 1,      1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, exp_vaddr, exp_cause});
      push(i, '{base + 1 + mw, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, exp_vaddr, exp_cause});
    end else begin
      push(i, '{base, exp_pcw, 1'b0, 1'b0, 1'b1, chk_m, exp_mux, exp_vaddr, 2'd0});
    end
    cls_s[i]   = cls;
    zero_s[i]  = z;
    oi_s[i]    = oi;
    ov_s[i]    = ov;
    dz_s[i]    = dz;
    start_s[i] = 1'b1;
    @(posedge clk);
    #1;
    start_s[i] = 1'b0;
    oi_s[i]    = 1'b0;
    ov_s[i]    = 1'b0;
    dz_s[i]    = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: pops one expectation per strobe cycle and compares everything.
  always @(negedge clk) begin
    ev_t e;
    bit  have;
    bit  ok;
    if (reset === 1'b0) begin
      for (int i = 0; i < 2; i++) begin
        if (pcw_o[i] || epcw_o[i] || mr_o[i] || done_o[i]) begin
          have = (i == 0) ? (q0.size() > 0) : (q1.size() > 0);
          checks++;
          if (!have) begin
            errors++;
            $display("FAIL unexpected_event dut%0d cyc=%0d pcw=%b epcw=%b mr=%b done=%b mux=%0d",
                     i, cyc, pcw_o[i], epcw_o[i], mr_o[i], done_o[i], mux_o[i]);
          end else begin
            if (i == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            ok = (cyc == e.cyc) && (pcw_o[i] == e.pc) && (epcw_o[i] == e.epc) &&
                 (mr_o[i] == e.mem) && (done_o[i] == e.dn) && (busy_o[i] == 1'b1) &&
                 (cause_o[i] == e.cause) && (!e.chk_mux || mux_o[i] == e.mux) &&
                 (!e.mem || vec_o[i] == e.vaddr);
            if (!ok) begin
              errors++;
              $display("FAIL event dut%0d: got cyc=%0d pcw=%b epcw=%b mr=%b done=%b busy=%b mux=%0d vec=%0d cause=%0d; want cyc=%0d pcw=%b epcw=%b mr=%b done=%b busy=1 mux=%0d(chk %b) vec=%0d cause=%0d",
                       i, cyc, pcw_o[i], epcw_o[i], mr_o[i], done_o[i], busy_o[i], mux_o[i],
                       vec_o[i], cause_o[i], e.cyc, e.pc, e.epc, e.mem, e.dn, e.mux,
                       e.chk_mux, e.vaddr, e.cause);
            end else begin
              $display("event dut%0d cyc=%0d pcw=%b epcw=%b mr=%b done=%b mux=%0d ok",
                       i, cyc, pcw_o[i], epcw_o[i], mr_o[i], done_o[i], mux_o[i]);
            end
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_mux"},   int'(mux_o[0]),   0);
    chk({tag, "_pcw"},   int'(pcw_o[0]),   0);
    chk({tag, "_epcw"},  int'(epcw_o[0]),  0);
    chk({tag, "_mr"},    int'(mr_o[0]),    0);
    chk({tag, "_vec"},   int'(vec_o[0]),   0);
    chk({tag, "_cause"}, int'(cause_o[0]), 0);
    chk({tag, "_busy"},  int'(busy_o[0]),  0);
    chk({tag, "_done"},  int'(done_o[0]),  0);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      start_s[i] = 1'b0; cls_s[i] = 3'd0; zero_s[i] = 1'b0;
      oi_s[i] = 1'b0; ov_s[i] = 1'b0; dz_s[i] = 1'b0;
    end
    reset = 1'b1;
    step(3);
    check_all_zero("reset");
    reset = 1'b0;
    step(1);

    // SEQ: select 1, write, done; idle the following cycle
    issue(0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 2'd0, 8'd0);
    chk("busy_in_apply", int'(busy_o[0]), 1);
    step(1);
    chk("busy_after_seq", int'(busy_o[0]), 0);

    // branches, both zero polarities
    issue(0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 2'd0, 8'd0);  // BEQ z=0
    step(1);
    issue(0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 1'b1, 2'd0, 8'd0);  // BNE z=0
    step(1);
    issue(0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 1'b1, 2'd0, 8'd0);  // BEQ z=1
    step(1);
    issue(0, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 2'd0, 8'd0);  // BNE z=1
    step(1);

    // J, JR, RTE each issued the cycle after done
    issue(0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 2'd0, 8'd0);
    step(1);
    issue(0, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 2'd0, 8'd0);
    step(1);
    issue(0, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 1'b1, 2'd0, 8'd0);
    step(1);

    // overflow + divZero on a J: cause 2, vector 254, load at N+4
    issue(0, 3'd3, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 2'd2, 8'd254);
    step(4);
    chk("busy_after_exc", int'(busy_o[0]), 0);
    chk("cause_held", int'(cause_o[0]), 2);

    // divZero on a reserved class; a start with opInvalid during EXC_WAIT
    // must be ignored
    issue(0, 3'd7, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 2'd3, 8'd255);
    step(2);  // now in EXC_WAIT
    cls_s[0] = 3'd0; oi_s[0] = 1'b1; start_s[0] = 1'b1;
    step(1);
    start_s[0] = 1'b0; oi_s[0] = 1'b0;
    chk("busy_in_load", int'(busy_o[0]), 1);
    step(1);
    chk("busy_after_ignored", int'(busy_o[0]), 0);
    chk("cause_not_relatched", int'(cause_o[0]), 3);

    // MEM_WAIT=1: all flags set, opInvalid wins, vector 253, load at N+3
    issue(1, 3'd1, 1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 2'd1, 8'd253);
    step(3);
    chk("b_busy_after_exc", int'(busy_o[1]), 0);
    // reserved class with no exception: done only
    issue(1, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 2'd0, 8'd253);
    step(1);

    // reset in the middle of EXC_WAIT
    issue(0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 2'd2, 8'd254);
    step(2);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("midreset");
    q0.delete();
    step(1);
    reset = 1'b0;
    step(1);
    issue(0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 2'd0, 8'd0);
    step(1);
    chk("busy_after_reset_seq", int'(busy_o[0]), 0);

    step(4);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Multicycle controller that sequences PC updates for the CPU datapath. Once per instruction it chooses the PC source mux select (`muxpcsource`) and strobes the PC write. For exceptions it runs a short sequence: save EPC, fetch the handler address byte from the memory vector, then load PC from the load/store control output. It sits between the main control FSM and the PC source mux / PC / EPC registers.

## Interface
- `MEM_WAIT`, default 2: memory read latency in cycles, 1..7.
- `VEC_BASE`, default 8'd253: address of the first exception vector byte.

Ports:
- `clk`  in  1: clock, rising edge.
- `reset`  in  1: asynchronous, active-high.
- `start`  in  1: one-cycle pulse; instruction decoded, operands/flags valid.
- `instrClass`  in  3: 0 SEQ, 1 BEQ, 2 BNE, 3 J, 4 JR, 5 RTE; 6–7 reserved.
- `zero`  in  1: ALU zero flag, sampled at `start`.
- `opInvalid`  in  1: invalid-opcode exception, sampled at `start`.
- `overflow`  in  1: arithmetic overflow exception, sampled at `start`.
- `divZero`  in  1: divide-by-zero exception, sampled at `start`.
- `muxpcsource`  out  3: PC source select (0 LSControlOut, 1 aluResult, 2 aluOutOut, 3 shiftLeft2Out, 4 epcOut).
- `pcWrite`  out  1: PC load strobe.
- `epcWrite`  out  1: EPC load strobe. The datapath presents PC−4 on aluResult.
- `memRead`  out  1: memory read strobe for the vector fetch.
- `vecAddr`  out  8: vector byte address, `VEC_BASE` + cause index.
- `excCause`  out  2: 0 none, 1 opInvalid, 2 overflow, 3 divZero. Holds until the next `start`.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse in the cycle the PC is written, or in the decision cycle when a branch is not taken.

## Operation
- States: IDLE, APPLY, EXC_EPC, EXC_READ, EXC_WAIT, EXC_LOAD.
- IDLE + `start`:
  - Register the class, `zero` and the exception flags.
  - Any exception goes to EXC_EPC; otherwise go to APPLY.
  - `start` while `busy` is ignored; no state change, no latching.
- Exception priority is opInvalid > overflow > divZero. `excCause` is set from the highest-priority flag. Cause index is `excCause`−1, so `vecAddr` is 253/254/255.
- An exception overrides `instrClass` entirely, including reserved codes.
- APPLY (1 cycle), then IDLE, by class:
  - SEQ: select 1, `pcWrite`=1.
  - BEQ: select 2, `pcWrite`=`zero`.
  - BNE: select 2, `pcWrite`=!`zero`.
  - J: select 3, `pcWrite`=1.
  - JR: select 1, `pcWrite`=1.
  - RTE: select 4, `pcWrite`=1.
  - Reserved class with no exception: `pcWrite`=0, `done`=1. Treated as a no-op; the decoder flags invalid opcodes.
  - `done`=1 in APPLY for every class.
- EXC_EPC (1 cycle): `epcWrite`=1.
- EXC_READ (1 cycle): `memRead`=1; `vecAddr` valid.
- EXC_WAIT: lasts `MEM_WAIT`−1 cycles, counted by a 3-bit down-counter. Skipped when `MEM_WAIT`=1. `vecAddr` is held.
- EXC_LOAD (1 cycle): select 0, `pcWrite`=1, `done`=1, then IDLE.
- Outside the cycles listed, `pcWrite`, `epcWrite`, `memRead` and `done` are 0.
- `muxpcsource` keeps its last value when not driven.

## Timing
- All outputs are registered or decoded from registered state; there is no combinational path from inputs to outputs.
- `start` at edge N:
  - Normal class: APPLY is active during cycle N+1; PC loads at edge N+2.
  - Exception: EPC write in cycle N+1, `memRead` in N+2, PC load in cycle N+2+`MEM_WAIT`.
  - Total exception occupancy is `MEM_WAIT`+2 cycles.
- The earliest next `start` accepted is the cycle after `done`.
- Reset values: state IDLE, `muxpcsource`=0, `pcWrite`=0, `epcWrite`=0, `memRead`=0, `vecAddr`=0, `excCause`=0, `busy`=0, `done`=0, counter 0.
- Reset asserted mid-sequence, including EXC_WAIT: outputs drop to reset values immediately (asynchronous). No partial PC write is produced after reset deasserts.

## Structure
- Shared package `cpu_pkg`:
  - `instr_class_t` enum.
  - `pcsrc_t` encodings for `muxpcsource` 0–4.
  - `exc_cause_t`.
  - `VEC_BASE` default.
- State enum is local to the module.
- No sub-module; the wait counter is inline.

## Test plan
- Reset, then `start` with class SEQ → cycle N+1: `muxpcsource`=1, `pcWrite`=1, `done`=1; next cycle `busy`=0.
- BEQ with `zero`=0, then BNE with `zero`=0:
  - BEQ → `muxpcsource`=2, `pcWrite`=0, `done`=1.
  - BNE → `pcWrite`=1.
- J, JR, RTE back-to-back, each `start` issued the cycle after `done` → selects 3, 1, 4 with `pcWrite`=1; all three accepted.
- `start` with `overflow`=1 and `divZero`=1, `MEM_WAIT`=2, class J:
  - `excCause`=2.
  - `epcWrite` at N+1.
  - `memRead` with `vecAddr`=254 at N+2.
  - select 0 with `pcWrite`=1 and `done`=1 at N+4.
  - No J select appears.
- `start` pulsed during EXC_WAIT is ignored; run again with `MEM_WAIT`=1: vector 253 for `opInvalid` → `pcWrite` at N+3.
- Assert `reset` during EXC_WAIT:
  - All outputs 0 in the same cycle.
  - After release, a SEQ `start` behaves per the first scenario with no stray `pcWrite`.
